// File: rtl/band_pkg.sv
// Shared constants, FSM state type and ROM layout helper for the band sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package band_pkg;

    localparam int NUM_BANDS  = 4;
    localparam int BAND_DEPTH = 4036;
    localparam int CLK_DIV    = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        EMIT = 2'd3
    } band_state_t;

    // Bands are packed back to back in the ROM, so a band's base is b*depth.
    function automatic int band_base(input int b, input int depth = BAND_DEPTH);
        return b * depth;
    endfunction

endpackage

// File: rtl/band_tick_gen.sv
// Sample-rate divider: one-cycle tick every CLK_DIV clk cycles.
// Latency: first tick CLK_DIV-1 cycles after reset release.
// Backpressure: none; free-running.
module band_tick_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign tick = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    // Count up, wrapping to zero on the tick cycle
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/band_playback_ctrl.sv
// Time-multiplexes one ROM port across all bands: per tick, fetch, tag and emit each band's sample.
// Latency: band k valid at tick+(k+1)*(ROM_LATENCY+2) cycles.
// Backpressure: none; a tick arriving mid-frame is dropped and sets sticky overrun.
module band_playback_ctrl #(
    parameter int NUM_BANDS    = band_pkg::NUM_BANDS,
    parameter int BAND_DEPTH   = band_pkg::BAND_DEPTH,
    parameter int CLK_DIV      = band_pkg::CLK_DIV,
    parameter int ROM_LATENCY  = 2,
    parameter int ADDR_WIDTH   = $clog2(NUM_BANDS * BAND_DEPTH),
    parameter int BAND_W       = $clog2(NUM_BANDS),
    parameter bit CHECK_TIMING = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BANDS-1:0]     start,
    input  logic [NUM_BANDS-1:0]     stop,
    input  logic [NUM_BANDS-1:0]     loop_en,
    output logic [ADDR_WIDTH-1:0]    rom_addr,
    input  logic [15:0]              rom_dout,
    output logic signed [15:0]       sample_out,
    output logic [BAND_W-1:0]        sample_band,
    output logic                     sample_valid,
    output logic                     frame_done,
    output logic [NUM_BANDS-1:0]     active,
    output logic                     overrun
);

    import band_pkg::*;

    localparam int                PTR_W     = $clog2(BAND_DEPTH);
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(BAND_DEPTH - 1);
    localparam logic [1:0]        LAST_WAIT = 2'(ROM_LATENCY - 1);

    // A whole frame must finish before the next tick; the overlap bench disables this check.
    if (CHECK_TIMING && (NUM_BANDS * (ROM_LATENCY + 2) >= CLK_DIV)) begin : g_frame_too_long
        $error("band_playback_ctrl: NUM_BANDS*(ROM_LATENCY+2) must be below CLK_DIV");
    end
    if ((ROM_LATENCY < 1) || (ROM_LATENCY > 2)) begin : g_bad_latency
        $error("band_playback_ctrl: ROM_LATENCY must be 1 or 2");
    end

    band_state_t             state_q, state_d;
    logic [BAND_W-1:0]       band_q, band_d;
    logic [1:0]              wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]             sample_q, sample_d;
    logic [BAND_W-1:0]       sample_band_q, sample_band_d;
    logic [PTR_W-1:0]        ptr_q [NUM_BANDS];
    logic [PTR_W-1:0]        ptr_d [NUM_BANDS];
    logic [NUM_BANDS-1:0]    active_q, active_d;
    logic                    overrun_q, overrun_d;
    logic                    tick;
    logic                    wait_last;

    band_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wait_last = (wait_q == LAST_WAIT);

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [BAND_W-1:0] b,
                                                      input logic [PTR_W-1:0]  p);
        return ADDR_WIDTH'(band_base(int'(b), BAND_DEPTH) + int'(p));
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one ADDR/WAIT/EMIT pass per band, back to IDLE after the last band
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = ADDR;
            ADDR:    state_d = WAIT;
            WAIT:    if (wait_last) state_d = EMIT;
            EMIT:    state_d = (band_q == LAST_BAND) ? IDLE : ADDR;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobes are decoded straight from the state so reset forces them low
    always_comb begin
        sample_valid = (state_q == EMIT);
        frame_done   = (state_q == EMIT) && (band_q == LAST_BAND);
    end

    // Datapath next state: capture, pointer advance, then commands, then the next ROM address
    always_comb begin
        band_d        = band_q;
        wait_d        = wait_q;
        rom_addr_d    = rom_addr_q;
        sample_d      = sample_q;
        sample_band_d = sample_band_q;
        ptr_d         = ptr_q;
        active_d      = active_q;
        overrun_d     = overrun_q | (tick && (state_q != IDLE));

        if (state_q == ADDR) begin
            wait_d = '0;
        end

        if (state_q == WAIT) begin
            wait_d = wait_q + 2'd1;
            if (wait_last) begin
                sample_d      = active_q[band_q] ? rom_dout : 16'd0;
                sample_band_d = band_q;
            end
        end

        if ((state_q == EMIT) && active_q[band_q]) begin
            if (ptr_q[band_q] != LAST_PTR) begin
                ptr_d[band_q] = ptr_q[band_q] + 1'b1;
            end else begin
                ptr_d[band_q] = '0;
                if (!loop_en[band_q]) begin
                    active_d[band_q] = 1'b0;
                end
            end
        end

        // Commands override the advance; stop beats start on the same band
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (stop[b]) begin
                active_d[b] = 1'b0;
                ptr_d[b]    = '0;
            end else if (start[b]) begin
                active_d[b] = 1'b1;
                ptr_d[b]    = '0;
            end
        end

        // Address uses the post-command pointer so a rewind is fetched immediately
        if ((state_q == IDLE) && tick) begin
            band_d     = '0;
            rom_addr_d = addr_of('0, ptr_d[0]);
        end else if ((state_q == EMIT) && (band_q != LAST_BAND)) begin
            band_d     = band_q + 1'b1;
            rom_addr_d = addr_of(band_q + 1'b1, ptr_d[band_q + 1'b1]);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            band_q        <= '0;
            wait_q        <= '0;
            rom_addr_q    <= '0;
            sample_q      <= '0;
            sample_band_q <= '0;
            ptr_q         <= '{default: '0};
            active_q      <= '0;
            overrun_q     <= 1'b0;
        end else begin
            band_q        <= band_d;
            wait_q        <= wait_d;
            rom_addr_q    <= rom_addr_d;
            sample_q      <= sample_d;
            sample_band_q <= sample_band_d;
            ptr_q         <= ptr_d;
            active_q      <= active_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sample_out  = sample_q;
    assign sample_band = sample_band_q;
    assign active      = active_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_band_playback_ctrl.sv
// Directed bench: default instance for frame timing/commands/reset, a fast L=1 instance for
// end-of-band wrap and stop, and an overlapping instance for the sticky overrun flag.
// Backpressure: n/a.
module tb_band_playback_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    bit fast_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- default instance (CLK_DIV=100, L=2) ----------------
    logic        rst;
    logic [3:0]  start, stop, loop_en, active;
    logic [13:0] rom_addr, rom_a1;
    logic [15:0] rom_dout;
    logic signed [15:0] sample_out;
    logic [1:0]  sample_band;
    logic        sample_valid, frame_done, overrun;

    band_playback_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .sample_out(sample_out),
        .sample_band(sample_band), .sample_valid(sample_valid), .frame_done(frame_done),
        .active(active), .overrun(overrun)
    );

    // ROM word = its own address, two-cycle read latency
    always_ff @(posedge clk) begin
        rom_a1   <= rom_addr;
        rom_dout <= 16'(rom_a1);
    end

    // ---------------- fast instance (CLK_DIV=13, L=1) ----------------
    logic        rst_f;
    logic [3:0]  f_start, f_stop, f_loop, f_active;
    logic [13:0] f_addr;
    logic [15:0] f_dout;
    logic signed [15:0] f_sample;
    logic [1:0]  f_band;
    logic        f_valid, f_done, f_overrun;

    band_playback_ctrl #(.CLK_DIV(13), .ROM_LATENCY(1)) dut_f (
        .clk(clk), .rst(rst_f), .start(f_start), .stop(f_stop), .loop_en(f_loop),
        .rom_addr(f_addr), .rom_dout(f_dout), .sample_out(f_sample),
        .sample_band(f_band), .sample_valid(f_valid), .frame_done(f_done),
        .active(f_active), .overrun(f_overrun)
    );

    always_ff @(posedge clk) f_dout <= 16'(f_addr);

    // ---------------- overlapping instance (CLK_DIV=10, check off) ----------------
    logic [3:0]  o_cmd;
    logic [3:0]  o_active;
    logic [13:0] o_addr, o_a1;
    logic [15:0] o_dout;
    logic signed [15:0] o_sample;
    logic [1:0]  o_band;
    logic        o_valid, o_done, o_overrun;

    assign o_cmd = 4'b0000;

    band_playback_ctrl #(.CLK_DIV(10), .CHECK_TIMING(1'b0)) dut_o (
        .clk(clk), .rst(rst), .start(o_cmd), .stop(o_cmd), .loop_en(o_cmd),
        .rom_addr(o_addr), .rom_dout(o_dout), .sample_out(o_sample),
        .sample_band(o_band), .sample_valid(o_valid), .frame_done(o_done),
        .active(o_active), .overrun(o_overrun)
    );

    always_ff @(posedge clk) begin
        o_a1   <= o_addr;
        o_dout <= 16'(o_a1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Wait for the next sample_valid of the default instance and check it
    task automatic m_expect(input string tag, input int band, input int smp, output int c);
        int n;
        n = 0;
        c = -1;
        @(negedge clk);
        while (sample_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sample_valid !== 1'b1) begin
            check({tag, " valid timeout"}, 32'(sample_valid), 32'd1);
        end else begin
            c = cyc - base;
            check({tag, " band"}, 32'(sample_band), 32'(band));
            check({tag, " sample"}, 32'($unsigned(sample_out)), 32'(smp));
            check({tag, " frame_done"}, 32'(frame_done), (band == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic m_frame(input string tag, input int e0, input int e1, input int e2,
                           input int e3, output int c0);
        int exp_s [4];
        int c, cp;
        exp_s = '{e0, e1, e2, e3};
        cp = 0;
        c0 = -1;
        for (int k = 0; k < 4; k++) begin
            m_expect($sformatf("%s b%0d", tag, k), k, exp_s[k], c);
            if (k == 0) c0 = c;
            else check($sformatf("%s gap%0d", tag, k), 32'(c - cp), 32'd4);
            cp = c;
        end
    endtask

    task automatic pulse(input logic [3:0] st, input logic [3:0] sp);
        @(negedge clk);
        start = st;
        stop  = sp;
        @(negedge clk);
        start = 4'b0000;
        stop  = 4'b0000;
    endtask

    // Fast-instance sample check; ok=0 on timeout
    task automatic f_expect(input string tag, input int band, input int smp, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (f_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (f_valid !== 1'b1) begin
            check({tag, " valid timeout"}, 32'(f_valid), 32'd1);
            ok = 1'b0;
        end else begin
            check({tag, " band"}, 32'(f_band), 32'(band));
            check({tag, " sample"}, 32'($unsigned(f_sample)), 32'(smp));
            check({tag, " frame_done"}, 32'(f_done), (band == 3) ? 32'd1 : 32'd0);
        end
    endtask

    // ---------------- fast instance: end-of-band stop (band 1) and loop (band 2) ----------------
    initial begin
        bit ok;
        bit abort;
        int e;
        abort   = 1'b0;
        rst_f   = 1'b1;
        f_start = 4'b0000;
        f_stop  = 4'b0000;
        f_loop  = 4'b0100;
        repeat (3) @(negedge clk);
        rst_f = 1'b0;
        @(negedge clk);
        f_start = 4'b0110;
        @(negedge clk);
        f_start = 4'b0000;
        check("fast active after start", 32'(f_active), 32'b0110);
        for (int n = 0; n <= 4036 && !abort; n++) begin
            for (int k = 0; k < 4 && !abort; k++) begin
                if (k == 1)      e = (n < 4036) ? 4036 + n : 0;
                else if (k == 2) e = 8072 + (n % 4036);
                else             e = 0;
                f_expect($sformatf("fast f%0d b%0d", n, k), k, e, ok);
                if (!ok) abort = 1'b1;
            end
            if (n == 4034) check("fast active before end", 32'(f_active), 32'b0110);
            if (n == 4035) check("fast active after end", 32'(f_active), 32'b0100);
        end
        fast_done = 1'b1;
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int c0, c1, c, n;
        rst     = 1'b1;
        start   = 4'b0000;
        stop    = 4'b0000;
        loop_en = 4'b0000;
        repeat (3) @(negedge clk);

        check("rst rom_addr", 32'(rom_addr), 32'd0);
        check("rst sample_out", 32'($unsigned(sample_out)), 32'd0);
        check("rst sample_valid", 32'(sample_valid), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst active", 32'(active), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst overlap overrun", 32'(o_overrun), 32'd0);

        rst  = 1'b0;
        base = cyc;

        // idle bands emit zeros; first tick at 99, first valid at 103
        m_frame("f1", 0, 0, 0, 0, c0);
        check("f1 first valid cycle", 32'(c0), 32'd103);
        check("f1 overrun", 32'(overrun), 32'd0);

        pulse(4'b0100, 4'b0000);
        m_frame("f2", 0, 0, 8072, 0, c1);
        check("tick period", 32'(c1 - c0), 32'd100);
        m_frame("f3", 0, 0, 8073, 0, c);
        check("f3 active", 32'(active), 32'b0100);

        // start and stop together: stop wins
        pulse(4'b0001, 4'b0001);
        check("start+stop active", 32'(active), 32'b0100);
        m_frame("f4", 0, 0, 8074, 0, c);

        pulse(4'b0001, 4'b0000);
        m_frame("f5", 0, 0, 8075, 0, c);
        check("f5 active", 32'(active), 32'b0101);

        // stop band 0 during its EMIT: overrides the advance
        m_expect("f6 b0", 0, 1, c);
        stop = 4'b0001;
        @(negedge clk);
        stop = 4'b0000;
        m_expect("f6 b1", 1, 0, c);
        m_expect("f6 b2", 2, 8076, c);
        m_expect("f6 b3", 3, 0, c);
        check("stop in emit ptr0", 32'(dut.ptr_q[0]), 32'd0);
        check("stop in emit active", 32'(active), 32'b0100);
        m_frame("f7", 0, 0, 8077, 0, c);

        // reset during band 1's WAIT
        m_expect("f8 b0", 0, 0, c);
        @(negedge clk);
        @(negedge clk);
        check("overlap overrun set", 32'(o_overrun), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sample_valid", 32'(sample_valid), 32'd0);
        check("midrst frame_done", 32'(frame_done), 32'd0);
        check("midrst sample_out", 32'($unsigned(sample_out)), 32'd0);
        check("midrst sample_band", 32'(sample_band), 32'd0);
        check("midrst rom_addr", 32'(rom_addr), 32'd0);
        check("midrst active", 32'(active), 32'd0);
        check("midrst overrun", 32'(overrun), 32'd0);
        check("midrst state", 32'(dut.state_q), 32'(band_pkg::IDLE));
        check("midrst ptr2", 32'(dut.ptr_q[2]), 32'd0);
        check("midrst overlap overrun", 32'(o_overrun), 32'd0);
        rst  = 1'b0;
        base = cyc;

        m_frame("f9", 0, 0, 0, 0, c0);
        check("post-rst first valid", 32'(c0), 32'd103);
        check("overlap overrun resets", 32'(o_overrun), 32'd1);

        n = 0;
        while (!fast_done && n < 80000) begin
            @(negedge clk);
            n++;
        end
        check("fast sequence done", 32'(fast_done), 32'd1);
        check("overlap overrun sticky", 32'(o_overrun), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
